// File: rtl/ysyx_23060236_mdu_ctrl_if.sv
// Handshake/data bundle between the MDU sequencer, the EXU-side producer and consumer,
// and the external multiplier/divider units.
interface ysyx_23060236_mdu_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    // EXU issue side
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      rd;
    logic            flush;

    // multiplier
    logic            mul_valid;
    logic            mul_ready;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic            mul_outvalid;
    logic [XLEN-1:0] mul_lo;
    logic [XLEN-1:0] mul_hi;

    // divider
    logic            div_valid;
    logic            div_ready;
    logic            div_signed;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic            div_outvalid;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;

    // result side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_val;
    logic [4:0]      out_rd;
    logic            busy;

    modport master (
        output in_valid, funct3, src1, src2, rd, flush,
        output mul_ready, mul_outvalid, mul_lo, mul_hi,
        output div_ready, div_outvalid, div_quot, div_rem,
        output out_ready,
        input  in_ready, mul_valid, mul_signed, mul_a, mul_b,
        input  div_valid, div_signed, div_a, div_b,
        input  out_valid, out_val, out_rd, busy
    );

    modport slave (
        input  in_valid, funct3, src1, src2, rd, flush,
        input  mul_ready, mul_outvalid, mul_lo, mul_hi,
        input  div_ready, div_outvalid, div_quot, div_rem,
        input  out_ready,
        output in_ready, mul_valid, mul_signed, mul_a, mul_b,
        output div_valid, div_signed, div_a, div_b,
        output out_valid, out_val, out_rd, busy
    );
endinterface

// File: rtl/ysyx_23060236_mdu_ctrl.sv
// RV32M sequencer: dispatches one op at a time to the external multiplier or divider,
// resolves div-by-zero and signed overflow locally, and holds the result for the consumer.
module ysyx_23060236_mdu_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input logic                     clock,
    input logic                     reset,
    ysyx_23060236_mdu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        MUL_REQ,
        MUL_WAIT,
        DIV_REQ,
        DIV_WAIT,
        DONE,
        DRAIN
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t          state;
    state_t          state_nxt;

    logic [2:0]      op_f3;
    logic [4:0]      op_rd;
    logic [1:0]      mul_signed_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic            div_signed_q;
    logic [XLEN-1:0] div_a_q;
    logic [XLEN-1:0] div_b_q;
    logic [XLEN-1:0] out_val_q;
    logic [4:0]      out_rd_q;

    logic            in_ready;
    logic            accept;
    logic            is_div_in;
    logic            div_zero;
    logic            div_ovf;
    logic            div_special;
    logic [XLEN-1:0] special_res;
    logic [1:0]      mul_signed_in;
    logic            load_res;
    logic [XLEN-1:0] res_nxt;
    logic            drain_done;

    assign in_ready  = (state == IDLE) && !bus.flush && !reset;
    assign accept    = bus.in_valid && in_ready;
    assign is_div_in = bus.funct3[2];

    // Div-by-zero and INT_MIN/-1 never reach the divider; their results are fixed by the ISA.
    assign div_zero    = (bus.src2 == '0);
    assign div_ovf     = !bus.funct3[0] && (bus.src1 == INT_MIN) && (bus.src2 == ALL_ONE);
    assign div_special = is_div_in && (div_zero || div_ovf);
    assign special_res = div_zero ? (bus.funct3[1] ? bus.src1 : ALL_ONE)
                                  : (bus.funct3[1] ? '0 : INT_MIN);

    // MUL/MULH: ss, MULHSU: su, MULHU: uu
    assign mul_signed_in = {~(bus.funct3[1] & bus.funct3[0]), ~bus.funct3[1]};

    assign drain_done = op_f3[2] ? bus.div_outvalid : bus.mul_outvalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
        res_nxt   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_div_in) begin
                        state_nxt = MUL_REQ;
                    end else if (div_special) begin
                        state_nxt = DONE;
                        load_res  = 1'b1;
                        res_nxt   = special_res;
                    end else begin
                        state_nxt = DIV_REQ;
                    end
                end
            end
            MUL_REQ: begin
                if (bus.flush) begin
                    state_nxt = bus.mul_ready ? DRAIN : IDLE;
                end else if (bus.mul_ready) begin
                    state_nxt = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                // A result arriving together with flush is already consumed, so no drain is needed.
                if (bus.flush) begin
                    state_nxt = bus.mul_outvalid ? IDLE : DRAIN;
                end else if (bus.mul_outvalid) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    res_nxt   = (op_f3[1:0] == 2'b00) ? bus.mul_lo : bus.mul_hi;
                end
            end
            DIV_REQ: begin
                if (bus.flush) begin
                    state_nxt = bus.div_ready ? DRAIN : IDLE;
                end else if (bus.div_ready) begin
                    state_nxt = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (bus.flush) begin
                    state_nxt = bus.div_outvalid ? IDLE : DRAIN;
                end else if (bus.div_outvalid) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    res_nxt   = op_f3[1] ? bus.div_rem : bus.div_quot;
                end
            end
            DONE: begin
                if (bus.flush || bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_f3        <= '0;
            op_rd        <= '0;
            mul_signed_q <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            div_signed_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            out_val_q    <= '0;
            out_rd_q     <= '0;
        end else begin
            if (accept) begin
                op_f3 <= bus.funct3;
                op_rd <= bus.rd;
                if (!is_div_in) begin
                    mul_signed_q <= mul_signed_in;
                    mul_a_q      <= bus.src1;
                    mul_b_q      <= bus.src2;
                end else if (!div_special) begin
                    div_signed_q <= ~bus.funct3[0];
                    div_a_q      <= bus.src1;
                    div_b_q      <= bus.src2;
                end
            end
            if (load_res) begin
                out_val_q <= res_nxt;
                out_rd_q  <= accept ? bus.rd : op_rd;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mul_valid  = (state == MUL_REQ);
    assign bus.mul_signed = mul_signed_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.div_valid  = (state == DIV_REQ);
    assign bus.div_signed = div_signed_q;
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;
    assign bus.out_valid  = (state == DONE);
    assign bus.out_val    = out_val_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_ysyx_23060236_mdu_ctrl.sv
// Scoreboard bench for the RV32M sequencer with behavioural multiplier/divider models.
module tb_ysyx_23060236_mdu_ctrl;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ysyx_23060236_mdu_ctrl_if #(.XLEN(32)) bus ();

    ysyx_23060236_mdu_ctrl #(.XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int          mul_cnt = 0;
    logic [63:0] mul_p;
    bit          spur_mul = 0;
    int          div_cnt = 0;
    int          div_stall = 0;
    logic [31:0] div_q;
    logic [31:0] div_r;
    bit          div_valid_seen = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        logic        sgn;
        if (!f3[2]) begin
            ea = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
            eb = f3[1] ? {32'b0, b} : {{32{b[31]}}, b};
            p  = ea * eb;
            return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        sgn = !f3[0];
        if (b == 32'h0) return f3[1] ? a : 32'hFFFFFFFF;
        if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'h0 : 32'h80000000;
        if (sgn) return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return f3[1] ? a % b : a / b;
    endfunction

    // Multiplier model: fixed latency, optional stray pulse on request.
    initial begin
        bus.mul_ready    = 1'b1;
        bus.mul_outvalid = 1'b0;
        bus.mul_lo       = '0;
        bus.mul_hi       = '0;
        forever begin
            @(negedge clock);
            bus.mul_outvalid = 1'b0;
            if (spur_mul) begin
                bus.mul_outvalid = 1'b1;
                bus.mul_lo       = 32'hDEADBEEF;
                bus.mul_hi       = 32'hDEADBEEF;
                spur_mul         = 0;
            end
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    bus.mul_outvalid = 1'b1;
                    bus.mul_lo       = mul_p[31:0];
                    bus.mul_hi       = mul_p[63:32];
                end
            end
            if (bus.mul_valid && bus.mul_ready) begin
                mul_p = (bus.mul_signed[1] ? {{32{bus.mul_a[31]}}, bus.mul_a} : {32'b0, bus.mul_a}) *
                        (bus.mul_signed[0] ? {{32{bus.mul_b[31]}}, bus.mul_b} : {32'b0, bus.mul_b});
                mul_cnt = MUL_LAT;
            end
        end
    end

    // Divider model: ready can be withheld for div_stall cycles of an asserted request.
    initial begin
        bus.div_ready    = 1'b1;
        bus.div_outvalid = 1'b0;
        bus.div_quot     = '0;
        bus.div_rem      = '0;
        forever begin
            @(negedge clock);
            bus.div_outvalid = 1'b0;
            if (bus.div_valid) begin
                div_valid_seen = 1;
                if (div_stall > 0) begin
                    bus.div_ready = 1'b0;
                    div_stall--;
                end else begin
                    bus.div_ready = 1'b1;
                end
            end else begin
                bus.div_ready = 1'b1;
            end
            if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    bus.div_outvalid = 1'b1;
                    bus.div_quot     = div_q;
                    bus.div_rem      = div_r;
                end
            end
            if (bus.div_valid && bus.div_ready) begin
                if (bus.div_b == 32'h0) begin
                    div_q = 32'hFFFFFFFF;
                    div_r = bus.div_a;
                end else if (bus.div_signed) begin
                    div_q = 32'($signed(bus.div_a) / $signed(bus.div_b));
                    div_r = 32'($signed(bus.div_a) % $signed(bus.div_b));
                end else begin
                    div_q = bus.div_a / bus.div_b;
                    div_r = bus.div_a % bus.div_b;
                end
                div_cnt = DIV_LAT;
            end
        end
    end

    // Result monitor: every accepted result must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_valid), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_val", bus.out_val, mon_e.val);
                    check("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input bit expect_res);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.src1     = a;
        bus.src2     = b;
        bus.rd       = r;
        @(negedge clock);
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("issue_timeout", 32'(n < 50), 32'h1);
        if (expect_res) sb.push_back('{rd: r, val: ref_result(f3, a, b)});
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_timeout", 32'(n < 100), 32'h1);
    endtask

    task automatic wait_ready_no_out(input string tag);
        int n = 0;
        bit seen = 0;
        while (!bus.in_ready && n < 20) begin
            if (bus.out_valid) seen = 1;
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_release"}, 32'(n < 20), 32'h1);
        check({tag, "_no_out"}, 32'(seen), 32'h0);
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [31:0] exp_v;
        bus.in_valid  = 1'b0;
        bus.funct3    = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.rd        = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_state_ready", 32'(bus.in_ready), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_mul_valid", 32'(bus.mul_valid), 32'h0);
        check("rst_div_valid", 32'(bus.div_valid), 32'h0);
        check("rst_out_val", bus.out_val, 32'h0);
        check("rst_mul_a", bus.mul_a, 32'h0);
        check("rst_div_b", bus.div_b, 32'h0);
        @(posedge clock);
        #1;

        issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 1);
        wait_drain();
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 1);
        wait_drain();
        issue(3'b010, 32'hFFFFFFFF, 32'd2, 5'd7, 1);
        wait_drain();
        issue(3'b001, 32'h80000000, 32'h80000000, 5'd8, 1);
        wait_drain();

        div_valid_seen = 0;
        issue(3'b100, 32'h64, 32'h0, 5'd9, 1);
        check("div0_latency", 32'(bus.out_valid), 32'h1);
        wait_drain();
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1);
        check("ovf_latency", 32'(bus.out_valid), 32'h1);
        wait_drain();
        issue(3'b111, 32'd5, 32'h0, 5'd11, 1);
        wait_drain();
        check("special_no_div_valid", 32'(div_valid_seen), 32'h0);

        div_stall = 4;
        issue(3'b100, 32'hFFFFFFEC, 32'd3, 5'd12, 1);
        for (int i = 0; i < 4; i++) begin
            check("stall_div_valid", 32'(bus.div_valid), 32'h1);
            check("stall_div_a", bus.div_a, 32'hFFFFFFEC);
            check("stall_div_b", bus.div_b, 32'd3);
            check("stall_div_signed", 32'(bus.div_signed), 32'h1);
            @(posedge clock);
            #1;
        end
        wait_drain();
        issue(3'b111, 32'd20, 32'd3, 5'd13, 1);
        wait_drain();

        // stray multiplier pulse while the divider is awaited
        issue(3'b100, 32'd1000, 32'd10, 5'd14, 1);
        n = 0;
        while (bus.div_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        spur_mul = 1;
        wait_drain();

        issue(3'b101, 32'd100, 32'd7, 5'd15, 0);
        n = 0;
        while (bus.div_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("divwait_hs_timeout", 32'(n < 20), 32'h1);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        check("divwait_flush_in_ready", 32'(bus.in_ready), 32'h0);
        check("divwait_flush_busy", 32'(bus.busy), 32'h1);
        wait_ready_no_out("divwait_flush");

        bus.in_valid = 1'b1;
        bus.funct3   = 3'b000;
        bus.src1     = 32'd3;
        bus.src2     = 32'd4;
        bus.flush    = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("idle_flush_in_ready", 32'(bus.in_ready), 32'h0);
            @(posedge clock);
            #1;
            check("idle_flush_busy", 32'(bus.busy), 32'h0);
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        issue(3'b000, 32'd5, 32'd6, 5'd16, 0);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        check("req_flush_in_ready", 32'(bus.in_ready), 32'h0);
        wait_ready_no_out("req_flush");

        bus.out_ready = 1'b0;
        exp_v = ref_result(3'b000, 32'd12345, 32'd678);
        issue(3'b000, 32'd12345, 32'd678, 5'd17, 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("hold_wait_timeout", 32'(n < 20), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(bus.out_valid), 32'h1);
            check("hold_out_val", bus.out_val, exp_v);
            check("hold_out_rd", 32'(bus.out_rd), 32'd17);
            check("hold_in_ready", 32'(bus.in_ready), 32'h0);
            @(posedge clock);
            #1;
        end
        bus.out_ready = 1'b1;
        wait_drain();

        issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd18, 0);
        @(posedge clock);
        #1;
        check("mulwait_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        check("midrst_out_val", bus.out_val, 32'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid || bus.busy) seen = 1;
            @(posedge clock);
            #1;
        end
        check("midrst_ignored", 32'(seen), 32'h0);

        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1);
        wait_drain();

        check("sb_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
